// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bundle: control strobes, ROM address/data and the decode handshake.
// master = fetch controller, slave = environment (core control, ROM, decode).
interface instr_fetch_ctrl_if #(
    parameter int ADDRESS_WIDTH     = 8,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         fetch_en;
    logic                         halt_req;
    logic                         redirect_valid;
    logic [ADDRESS_WIDTH-1:0]     redirect_pc;
    logic [ADDRESS_WIDTH-1:0]     mem_addr;
    logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
    logic                         if_valid;
    logic                         if_ready;
    logic [INSTRUCTION_WIDTH-1:0] if_instr;
    logic [ADDRESS_WIDTH-1:0]     if_pc;
    logic                         busy;

    modport master (
        input  fetch_en, halt_req, redirect_valid, redirect_pc, mem_rdata, if_ready,
        output mem_addr, if_valid, if_instr, if_pc, busy
    );

    modport slave (
        output fetch_en, halt_req, redirect_valid, redirect_pc, mem_rdata, if_ready,
        input  mem_addr, if_valid, if_instr, if_pc, busy
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads an async ROM, buffers {pc, instr} for decode.
// Latency: first push the cycle after start, head valid one cycle later; one instr/cycle steady state.
// Backpressure: FIFO fills to BUF_DEPTH then PC and ROM address hold until decode accepts.
module instr_fetch_ctrl #(
    parameter int          ADDRESS_WIDTH     = 8,
    parameter int          INSTRUCTION_WIDTH = 32,
    parameter int          BUF_DEPTH         = 2,
    parameter int unsigned RESET_PC          = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_ctrl_if.master    bus
);
    localparam int AW    = ADDRESS_WIDTH;
    localparam int IW    = INSTRUCTION_WIDTH;
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } entry_t;

    logic [1:0]       state, state_nxt;
    logic [AW-1:0]    pc;
    entry_t           buf_q [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             redirect, push, pop;

    assign redirect = bus.redirect_valid;
    assign pop      = bus.if_valid && bus.if_ready && !redirect;
    assign push     = (state == S_RUN) && !bus.halt_req && !redirect &&
                      ((count < CNT_W'(BUF_DEPTH)) || pop);

    assign bus.mem_addr = pc;
    assign bus.if_valid = (count != '0);
    assign bus.if_instr = buf_q[rd_ptr].instr;
    assign bus.if_pc    = buf_q[rd_ptr].pc;
    assign bus.busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.fetch_en)                 state_nxt = S_RUN;
            S_RUN:   if (bus.halt_req && !redirect)    state_nxt = S_HALT;
            S_HALT:  if (!bus.halt_req || redirect)    state_nxt = S_RUN;
            default:                                   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= AW'(RESET_PC);
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                // Flush discards queued entries; the low two target bits are dropped to word-align.
                pc     <= bus.redirect_pc & ~AW'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    buf_q[wr_ptr] <= '{pc: pc, instr: bus.mem_rdata};
                    wr_ptr        <= wr_ptr + PTR_W'(1);
                    pc            <= pc + AW'(4);
                end
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)      count <= count + CNT_W'(1);
                else if (pop && !push) count <= count - CNT_W'(1);
            end
        end
    end
endmodule
